// File: rtl/hmc_tx_token_ctrl.sv
// HMC TX token controller: tracks input-buffer tokens on the transmit side.
// Tokens are loaded from the configured value, consumed by granted FLITs and
// credited from the RTC fields of up to FPW returned FLITs per cycle. Returns
// pass through one register stage before they are credited.
module hmc_tx_token_ctrl #(
    parameter int FPW                = 4,
    parameter int LOG_FPW            = 2,
    parameter int LOG_MAX_HMC_TOKENS = 10,
    parameter int RTC_W              = 5,
    parameter int DBG_TOKEN_MON      = 1
) (
    input  logic                          clk,
    input  logic                          res_n,
    input  logic                          init_load,
    input  logic [LOG_MAX_HMC_TOKENS-1:0] init_tokens,
    input  logic [FPW-1:0]                rtc_valid,
    input  logic [FPW*RTC_W-1:0]          rtc_val,
    input  logic                          req_valid,
    input  logic [LOG_FPW:0]              req_flits,
    output logic                          grant,
    output logic [LOG_MAX_HMC_TOKENS:0]   avail_tokens,
    output logic                          tokens_zero,
    output logic                          overflow_err,
    input  logic                          dbg_clr,
    output logic [LOG_MAX_HMC_TOKENS:0]   dbg_min_tokens
);

    // Token count width holds the full 2**LOG_MAX_HMC_TOKENS value; one extra
    // bit on the intermediate sum lets overflow be seen before saturation.
    localparam int TW = LOG_MAX_HMC_TOKENS + 1;
    localparam int NW = TW + 1;
    localparam int FW = LOG_FPW + 1;

    localparam logic [TW-1:0] MAX_TOK   = TW'(2**LOG_MAX_HMC_TOKENS);
    localparam logic [NW-1:0] MAX_FULL  = NW'(2**LOG_MAX_HMC_TOKENS);
    localparam logic [FW-1:0] FLITS_MAX = FW'(FPW);

    typedef enum logic [1:0] {
        ST_UNINIT = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] avail_q, avail_d;
    logic [TW-1:0] ret_q, ret_d;
    logic          ovf_q, ovf_d;

    logic [TW-1:0] ret_sum;
    logic [NW-1:0] next_full;
    logic          overflow_hit;
    logic [TW-1:0] next_sat;

    // Sum the RTC fields of all valid slots at full token width.
    always_comb begin
        ret_sum = '0;
        for (int i = 0; i < FPW; i++) begin
            if (rtc_valid[i]) begin
                ret_sum = ret_sum + TW'(rtc_val[i*RTC_W +: RTC_W]);
            end
        end
    end

    // Grant uses only the registered count, so the pending return in ret_q
    // never enables a request in the cycle it is being credited.
    assign grant = (state_q == ST_ACTIVE) && req_valid && !init_load &&
                   (req_flits != '0) && (req_flits <= FLITS_MAX) &&
                   (TW'(req_flits) <= avail_q);

    assign next_full    = {1'b0, avail_q} - (grant ? NW'(req_flits) : '0) + {1'b0, ret_q};
    assign overflow_hit = (next_full > MAX_FULL);
    assign next_sat     = overflow_hit ? MAX_TOK : next_full[TW-1:0];

    // Next-state logic: init_load wins over everything; only ACTIVE moves tokens.
    always_comb begin
        state_d = state_q;
        avail_d = avail_q;
        ovf_d   = ovf_q;
        ret_d   = ret_sum;
        if (init_load) begin
            state_d = ST_ACTIVE;
            avail_d = TW'(init_tokens);
            ret_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    avail_d = next_sat;
                    if (overflow_hit) begin
                        state_d = ST_ERR;
                        ovf_d   = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and token registers, cleared asynchronously.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_UNINIT;
            avail_q <= '0;
            ret_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            avail_q <= avail_d;
            ret_q   <= ret_d;
            ovf_q   <= ovf_d;
        end
    end

    assign avail_tokens = avail_q;
    assign tokens_zero  = (avail_q == '0);
    assign overflow_err = ovf_q;

    generate
        if (DBG_TOKEN_MON != 0) begin : g_dbg
            logic [TW-1:0] dbg_min_q, dbg_min_d;

            // Low-watermark tracking of the post-update count while ACTIVE.
            always_comb begin
                dbg_min_d = dbg_min_q;
                if (init_load) begin
                    dbg_min_d = TW'(init_tokens);
                end else if (state_q == ST_ACTIVE) begin
                    if (dbg_clr || (next_sat < dbg_min_q)) begin
                        dbg_min_d = next_sat;
                    end
                end
            end

            // Watermark register.
            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    dbg_min_q <= '0;
                end else begin
                    dbg_min_q <= dbg_min_d;
                end
            end

            assign dbg_min_tokens = dbg_min_q;
        end else begin : g_no_dbg
            assign dbg_min_tokens = '0;
        end
    endgenerate

endmodule

// File: tb/tb_hmc_tx_token_ctrl.sv
// Self-checking bench for hmc_tx_token_ctrl: directed scenarios plus a
// randomized run compared against an integer token-accounting model.
module tb_hmc_tx_token_ctrl;

    localparam int FPW   = 4;
    localparam int LOG_FPW = 2;
    localparam int L     = 10;
    localparam int RTC_W = 5;
    localparam int MAXT  = 1024;

    logic               clk = 1'b0;
    logic               res_n;
    logic               init_load;
    logic [L-1:0]       init_tokens;
    logic [FPW-1:0]     rtc_valid;
    logic [FPW*RTC_W-1:0] rtc_val;
    logic               req_valid;
    logic [LOG_FPW:0]   req_flits;
    logic               grant;
    logic [L:0]         avail_tokens;
    logic               tokens_zero;
    logic               overflow_err;
    logic               dbg_clr;
    logic [L:0]         dbg_min_tokens;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = not initialised, 1 = counting, 2 = error (frozen).
    int m_mode, m_avail, m_ret, m_min;
    bit m_ovf;

    hmc_tx_token_ctrl #(
        .FPW(FPW), .LOG_FPW(LOG_FPW), .LOG_MAX_HMC_TOKENS(L),
        .RTC_W(RTC_W), .DBG_TOKEN_MON(1)
    ) dut (
        .clk(clk), .res_n(res_n), .init_load(init_load), .init_tokens(init_tokens),
        .rtc_valid(rtc_valid), .rtc_val(rtc_val), .req_valid(req_valid),
        .req_flits(req_flits), .grant(grant), .avail_tokens(avail_tokens),
        .tokens_zero(tokens_zero), .overflow_err(overflow_err), .dbg_clr(dbg_clr),
        .dbg_min_tokens(dbg_min_tokens)
    );

    always #5 clk = ~clk;

    function automatic int m_grant();
        int f;
        if (m_mode != 1 || !req_valid || init_load) return 0;
        f = int'(req_flits);
        if (f < 1 || f > FPW) return 0;
        return (f <= m_avail) ? 1 : 0;
    endfunction

    function automatic int slot_sum();
        int s = 0;
        for (int i = 0; i < FPW; i++)
            if (rtc_valid[i]) s += int'(rtc_val[i*RTC_W +: RTC_W]);
        return s;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_avail = 0; m_ret = 0; m_min = 0; m_ovf = 0;
    endtask

    // Advance one clock edge, updating the model from the inputs held stable.
    task automatic tick();
        int g, rs, n;
        g  = m_grant();
        rs = slot_sum();
        @(posedge clk);
        if (init_load) begin
            m_mode = 1; m_avail = int'(init_tokens); m_ret = 0; m_ovf = 0;
            m_min = int'(init_tokens);
        end else if (m_mode == 1) begin
            n = m_avail - (g != 0 ? int'(req_flits) : 0) + m_ret;
            if (n > MAXT) begin
                n = MAXT; m_ovf = 1; m_mode = 2;
            end
            if (dbg_clr || n < m_min) m_min = n;
            m_avail = n;
            m_ret = rs;
        end else begin
            m_ret = rs;
        end
        #1;
    endtask

    task automatic idle();
        init_load = 0; init_tokens = '0; rtc_valid = '0; rtc_val = '0;
        req_valid = 0; req_flits = '0; dbg_clr = 0;
    endtask

    task automatic set_slot(input int i, input int v);
        rtc_valid[i] = 1'b1;
        rtc_val[i*RTC_W +: RTC_W] = RTC_W'(v);
    endtask

    task automatic do_load(input int n);
        idle();
        init_load = 1; init_tokens = L'(n);
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        res_n = 0;
        req_valid = 1; req_flits = 3'd1; set_slot(0, 9);
        model_reset();
        #2;
        checks++; if (avail_tokens !== 11'd0) begin errors++; $display("FAIL reset_avail: got %0d expected 0", avail_tokens); end
        checks++; if (tokens_zero !== 1'b1) begin errors++; $display("FAIL reset_tz: got %0b expected 1", tokens_zero); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", overflow_err); end
        checks++; if (dbg_min_tokens !== 11'd0) begin errors++; $display("FAIL reset_dbg: got %0d expected 0", dbg_min_tokens); end
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %0b expected 0", grant); end
        @(posedge clk); @(posedge clk); #1;
        res_n = 1;
        tick();
        checks++; if (avail_tokens !== 11'd0 || grant !== 1'b0) begin errors++; $display("FAIL uninit_hold: got avail %0d grant %0b expected 0 0", avail_tokens, grant); end
        idle();
    endtask

    task automatic test_init_load();
        idle();
        init_load = 1; init_tokens = 10'd100;
        req_valid = 1; req_flits = 3'd2; set_slot(1, 30);
        #1;
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL load_grant: got %0b expected 0", grant); end
        tick();
        idle();
        checks++; if (avail_tokens !== 11'd100) begin errors++; $display("FAIL load_avail: got %0d expected 100", avail_tokens); end
        checks++; if (tokens_zero !== 1'b0) begin errors++; $display("FAIL load_tz: got %0b expected 0", tokens_zero); end
        checks++; if (dbg_min_tokens !== 11'd100) begin errors++; $display("FAIL load_dbg: got %0d expected 100", dbg_min_tokens); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL load_ovf: got %0b expected 0", overflow_err); end
        tick(); tick();
        checks++; if (avail_tokens !== 11'd100) begin errors++; $display("FAIL load_rtc_discard: got %0d expected 100", avail_tokens); end
    endtask

    task automatic test_grant_boundary();
        do_load(3);
        req_valid = 1; req_flits = 3'd4; #1;
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL grant_4_of_3: got %0b expected 0", grant); end
        tick();
        checks++; if (avail_tokens !== 11'd3) begin errors++; $display("FAIL avail_after_deny: got %0d expected 3", avail_tokens); end
        req_flits = 3'd0; #1;
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL grant_zero_flits: got %0b expected 0", grant); end
        req_flits = 3'd3; #1;
        checks++; if (grant !== 1'b1) begin errors++; $display("FAIL grant_3_of_3: got %0b expected 1", grant); end
        tick();
        idle();
        checks++; if (avail_tokens !== 11'd0) begin errors++; $display("FAIL avail_drained: got %0d expected 0", avail_tokens); end
        checks++; if (tokens_zero !== 1'b1) begin errors++; $display("FAIL tz_drained: got %0b expected 1", tokens_zero); end
        checks++; if (dbg_min_tokens !== 11'd0) begin errors++; $display("FAIL dbg_drained: got %0d expected 0", dbg_min_tokens); end
        do_load(500);
        req_valid = 1; req_flits = 3'd5; #1;
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL grant_over_fpw: got %0b expected 0", grant); end
        idle();
    endtask

    task automatic test_return_latency();
        do_load(10);
        set_slot(0, 5); set_slot(1, 7); set_slot(3, 31);
        rtc_val[2*RTC_W +: RTC_W] = 5'd9;
        tick();
        idle();
        checks++; if (avail_tokens !== 11'd10) begin errors++; $display("FAIL ret_one_edge: got %0d expected 10", avail_tokens); end
        tick();
        checks++; if (avail_tokens !== 11'd53) begin errors++; $display("FAIL ret_two_edges: got %0d expected 53", avail_tokens); end
    endtask

    task automatic test_consume_credit();
        do_load(20);
        set_slot(0, 10);
        tick();
        idle();
        req_valid = 1; req_flits = 3'd4; #1;
        checks++; if (grant !== 1'b1) begin errors++; $display("FAIL cc_grant: got %0b expected 1", grant); end
        tick();
        idle();
        checks++; if (avail_tokens !== 11'd26) begin errors++; $display("FAIL cc_avail: got %0d expected 26", avail_tokens); end
    endtask

    task automatic test_watermark();
        do_load(100);
        req_valid = 1; req_flits = 3'd4; set_slot(0, 25); set_slot(1, 25);
        tick();
        idle();
        checks++; if (dbg_min_tokens !== 11'd96) begin errors++; $display("FAIL wm_min: got %0d expected 96", dbg_min_tokens); end
        dbg_clr = 1;
        tick();
        idle();
        checks++; if (avail_tokens !== 11'd146 || dbg_min_tokens !== 11'd146) begin errors++; $display("FAIL wm_clr: got avail %0d dbg %0d expected 146 146", avail_tokens, dbg_min_tokens); end
        req_valid = 1; req_flits = 3'd3;
        tick();
        idle();
        checks++; if (dbg_min_tokens !== 11'd143) begin errors++; $display("FAIL wm_track: got %0d expected 143", dbg_min_tokens); end
    endtask

    task automatic test_overflow();
        do_load(1020);
        set_slot(0, 4); set_slot(2, 6);
        tick();
        idle();
        tick();
        checks++; if (avail_tokens !== 11'd1024) begin errors++; $display("FAIL ovf_sat: got %0d expected 1024", avail_tokens); end
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow_err); end
        req_valid = 1; req_flits = 3'd1; set_slot(1, 20); #1;
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL ovf_grant: got %0b expected 0", grant); end
        tick(); tick(); tick();
        checks++; if (avail_tokens !== 11'd1024) begin errors++; $display("FAIL ovf_frozen: got %0d expected 1024", avail_tokens); end
        do_load(50);
        checks++; if (overflow_err !== 1'b0 || avail_tokens !== 11'd50) begin errors++; $display("FAIL ovf_reload: got ovf %0b avail %0d expected 0 50", overflow_err, avail_tokens); end
        req_valid = 1; req_flits = 3'd2; #1;
        checks++; if (grant !== 1'b1) begin errors++; $display("FAIL ovf_resume: got %0b expected 1", grant); end
        tick();
        idle();
        checks++; if (avail_tokens !== 11'd48) begin errors++; $display("FAIL ovf_resume_avail: got %0d expected 48", avail_tokens); end
    endtask

    task automatic test_zero_init();
        do_load(0);
        checks++; if (tokens_zero !== 1'b1) begin errors++; $display("FAIL zinit_tz: got %0b expected 1", tokens_zero); end
        req_valid = 1; req_flits = 3'd1; set_slot(3, 2); #1;
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL zinit_grant0: got %0b expected 0", grant); end
        tick();
        rtc_valid = '0;
        tick();
        #1;
        checks++; if (avail_tokens !== 11'd2 || grant !== 1'b1) begin errors++; $display("FAIL zinit_resume: got avail %0d grant %0b expected 2 1", avail_tokens, grant); end
        idle();
    endtask

    task automatic test_async_reset();
        do_load(200);
        set_slot(0, 20); set_slot(1, 11);
        tick();
        req_valid = 1; req_flits = 3'd1;
        #3;
        res_n = 0;
        model_reset();
        #1;
        checks++; if (avail_tokens !== 11'd0 || tokens_zero !== 1'b1 || overflow_err !== 1'b0 || dbg_min_tokens !== 11'd0 || grant !== 1'b0) begin
            errors++; $display("FAIL async_reset: got avail %0d tz %0b ovf %0b dbg %0d grant %0b expected 0 1 0 0 0", avail_tokens, tokens_zero, overflow_err, dbg_min_tokens, grant);
        end
        #1;
        res_n = 1;
        tick(); tick(); tick();
        checks++; if (avail_tokens !== 11'd0 || grant !== 1'b0) begin errors++; $display("FAIL async_no_credit: got avail %0d grant %0b expected 0 0", avail_tokens, grant); end
        idle();
    endtask

    task automatic test_random();
        do_load(500);
        for (int c = 0; c < 400; c++) begin
            idle();
            if ($urandom_range(0, 39) == 0 || (m_mode == 2 && $urandom_range(0, 3) == 0)) begin
                init_load = 1; init_tokens = L'($urandom_range(0, 1023));
            end
            req_valid = ($urandom_range(0, 9) < 7);
            req_flits = 3'($urandom_range(0, 7));
            dbg_clr   = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < FPW; i++)
                if ($urandom_range(0, 1) == 1)
                    set_slot(i, ($urandom_range(0, 19) == 0) ? 31 : int'($urandom_range(0, 3)));
            #1;
            checks++; if (grant !== (m_grant() != 0)) begin errors++; $display("FAIL rnd_grant cyc %0d: got %0b expected %0d", c, grant, m_grant()); end
            tick();
            checks++; if (avail_tokens !== 11'(m_avail) || tokens_zero !== (m_avail == 0)) begin errors++; $display("FAIL rnd_avail cyc %0d: got %0d expected %0d", c, avail_tokens, m_avail); end
            checks++; if (overflow_err !== m_ovf || dbg_min_tokens !== 11'(m_min)) begin errors++; $display("FAIL rnd_ovf_dbg cyc %0d: got ovf %0b dbg %0d expected %0b %0d", c, overflow_err, dbg_min_tokens, m_ovf, m_min); end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_init_load();
        test_grant_boundary();
        test_return_latency();
        test_consume_credit();
        test_watermark();
        test_overflow();
        test_zero_init();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hmc_tx_token_ctrl.md
Name: hmc_tx_token_ctrl

Overview:
- Tracks HMC input-buffer tokens on the TX side of the link controller.
- Tokens are loaded from the HMC token configuration value, decremented as FLITs are granted for transmission, and credited from the RTC fields of up to FPW incoming FLITs per cycle.
- Sits between the TX link FSM (requester) and the RX link (token return source).
- Generalises the fixed single-slot token counter to FPW slots, a configurable depth, overflow detection and a debug low-watermark monitor.

Parameters:
- FPW, 4, FLITs per word; legal values 2, 4, 6, 8.
- LOG_FPW, 2, ceil(log2(FPW)); 1 for FPW=2, 2 for FPW=4, 3 for FPW=6/8.
- LOG_MAX_HMC_TOKENS, 10, log2 of maximum token count; must be >= log2 of the HMC buffer size.
- RTC_W, 5, width of one RTC field.
- DBG_TOKEN_MON, 1, 0 removes the watermark logic; dbg_min_tokens is then tied to 0.

Ports:
- clk  in  1  controller clock.
- res_n  in  1  asynchronous active-low reset.
- init_load  in  1  load init_tokens and enter ACTIVE.
- init_tokens  in  LOG_MAX_HMC_TOKENS  initial token count.
- rtc_valid  in  FPW  per-slot RTC valid.
- rtc_val  in  FPW*RTC_W  per-slot returned tokens; slot i = bits [i*RTC_W +: RTC_W].
- req_valid  in  1  TX requests to send req_flits FLITs.
- req_flits  in  LOG_FPW+1  FLIT count, 1..FPW.
- grant  out  1  request accepted this cycle (combinational).
- avail_tokens  out  LOG_MAX_HMC_TOKENS+1  current token count (registered).
- tokens_zero  out  1  avail_tokens == 0.
- overflow_err  out  1  sticky error flag.
- dbg_clr  in  1  re-arm the watermark.
- dbg_min_tokens  out  LOG_MAX_HMC_TOKENS+1  lowest avail_tokens since load or dbg_clr.

Behaviour:
- Reset (res_n low, asynchronous):
  - state = UNINIT, avail_tokens = 0, return pipeline register = 0.
  - overflow_err = 0, dbg_min_tokens = 0, tokens_zero = 1, grant = 0.
  - Reset asserted mid-operation discards all in-flight returns.
- FSM states:
  - UNINIT -> ACTIVE on init_load.
  - ACTIVE -> ERR on overflow.
  - ERR -> ACTIVE on init_load.
  - ACTIVE -> ACTIVE on init_load (reload).
  - No other transitions.
- Return path:
  - ret_sum = sum over slots with rtc_valid[i]=1 of rtc_val slot i; computed at width LOG_MAX_HMC_TOKENS+1, no truncation (max FPW*31=248 fits).
  - ret_sum is registered into ret_q; a return is credited exactly 1 cycle after rtc_valid.
- Grant (combinational):
  - grant = (state==ACTIVE) && req_valid && !init_load && req_flits!=0 && req_flits <= avail_tokens.
  - Decided on registered avail_tokens only; ret_q is not used for the grant decision.
  - req_flits > FPW is illegal; grant=0 for it.
- Update in ACTIVE, per clock:
  - next = avail_tokens - (grant ? req_flits : 0) + ret_q.
  - Consume and credit in the same cycle both apply.
- Overflow:
  - Condition: next > 2**LOG_MAX_HMC_TOKENS.
  - Effect: avail_tokens saturates to 2**LOG_MAX_HMC_TOKENS, overflow_err=1, state=ERR.
  - In ERR: grant=0; avail_tokens is frozen; returns are ignored.
- init_load:
  - Takes priority over every other input.
  - avail_tokens = zero-extended init_tokens, ret_q cleared, overflow_err cleared, dbg_min_tokens = init_tokens.
  - Same-cycle requests get grant=0; same-cycle rtc_valid is discarded.
- UNINIT: avail_tokens held at 0; returns ignored; grant=0.
- tokens_zero is derived from registered avail_tokens.
- Watermark (DBG_TOKEN_MON=1, ACTIVE only):
  - dbg_min_tokens = min(dbg_min_tokens, next) every cycle.
  - dbg_clr sets dbg_min_tokens = next.
  - init_load overrides dbg_clr.
- init_tokens = 0 is legal: ACTIVE with zero tokens; grants begin only after returns arrive.

Test Plan:
- Reset, init_load with init_tokens=100 -> next cycle avail_tokens=100, tokens_zero=0, dbg_min_tokens=100, overflow_err=0.
- avail=3, req_flits=4 -> grant=0, avail stays 3; req_flits=3 -> grant=1, next cycle avail=0, tokens_zero=1, dbg_min_tokens=0.
- FPW=4, rtc_valid=4'b1011, slot values 5/7/9/31 -> avail increases by 43 two clock edges later (ret_q stage), not one.
- Simultaneous grant of 4 and ret_q=10 with avail=20 -> avail=26.
- avail=1020 (max 1024), returns summing 10 -> avail=1024, overflow_err=1, state ERR, subsequent requests grant=0; init_load 50 -> overflow_err=0, avail=50, grants resume.
- res_n pulsed low asynchronously while rtc_valid active -> all outputs at reset values immediately; no credit appears after res_n deasserts.
